hazard_scoreboard: RTL and testbench

Parametrised load-use hazard detector for the in-order pipeline, sitting between the IF/ID register and the decode stage. It tracks every load in flight with a LOAD_LAT-deep destination scoreboard, stalls PC and IF/ID while a decoded instruction reads a pending load destination, and injects an ID/EX bubble for each stall cycle. It generalises the single-cycle load-use check to configurable instruction and register-field geometry and multi-cycle memory latency, and adds a saturating stall counter.

---
 rtl/hazard_scoreboard.sv | 68 ++++++
 tb/tb_hazard_scoreboard.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use hazard detector with a LOAD_LAT-deep destination scoreboard and saturating stall counter.
// Define HAZ_BRANCH_FLUSH_EN to add branchTaken/IFIDFlush, which squash the IF/ID instruction.
module hazard_scoreboard #(
    parameter int INSTR_W  = 16,
    parameter int REG_W    = 4,
    parameter int OP1_LSB  = 8,
    parameter int OP2_LSB  = 4,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instrValid,
    input  logic               mRead,
`ifdef HAZ_BRANCH_FLUSH_EN
    input  logic               branchTaken,
    output logic               IFIDFlush,
`endif
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               IDEXBubble,
    output logic [CNT_W-1:0]   stallCount
);
    logic [LOAD_LAT-1:0] sb_v;
    logic [REG_W-1:0]    sb_rd [LOAD_LAT];
    logic [REG_W-1:0]    op1, op2;
    logic                id_live, hit, stall;

    assign op1 = instruction[OP1_LSB +: REG_W];
    assign op2 = instruction[OP2_LSB +: REG_W];
`ifdef HAZ_BRANCH_FLUSH_EN
    assign id_live   = instrValid & ~branchTaken;
    assign IFIDFlush = branchTaken;
`else
    assign id_live   = instrValid;
`endif

    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++)
            hit = hit | (sb_v[k] & ((sb_rd[k] == op1) | (sb_rd[k] == op2)));
    end

    assign stall      = id_live & hit;
    assign PCWrite    = ~stall;
    assign IFIDWrite  = ~stall;
    assign IDEXBubble = stall;

    // a stalled instruction enters as a bubble; it is re-examined next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v       <= '0;
            stallCount <= '0;
            for (int k = 0; k < LOAD_LAT; k++)
                sb_rd[k] <= '0;
        end else begin
            for (int k = LOAD_LAT - 1; k > 0; k--) begin
                sb_v[k]  <= sb_v[k-1];
                sb_rd[k] <= sb_rd[k-1];
            end
            sb_v[0]  <= ~stall & id_live & mRead;
            sb_rd[0] <= stall ? '0 : op1;
            if (stall && stallCount != '1)
                stallCount <= stallCount + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed plus randomized checks of hazard_scoreboard against a busy-until model.
// Exercises the HAZ_BRANCH_FLUSH_EN ports only when that macro is defined.
module tb_hazard_scoreboard;
    localparam int L     = 3;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic              clk = 0, rst = 1;
    logic [15:0]       instruction = '0;
    logic              instrValid = 0, mRead = 0, branchTaken = 0;
    logic              PCWrite, IFIDWrite, IDEXBubble, IFIDFlush;
    logic [CNT_W-1:0]  stallCount;

    int passed = 0, total = 0;
    int cyc = 0, cnt = 0;
    int busy [16];

    hazard_scoreboard #(.LOAD_LAT(L), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .instrValid(instrValid), .mRead(mRead),
`ifdef HAZ_BRANCH_FLUSH_EN
        .branchTaken(branchTaken), .IFIDFlush(IFIDFlush),
`endif
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble), .stallCount(stallCount)
    );

`ifndef HAZ_BRANCH_FLUSH_EN
    assign IFIDFlush = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        foreach (busy[r]) busy[r] = -1;
        cnt = 0;
    endtask

    // a load advancing at cycle t makes its destination unusable through cycle t+L
    function automatic bit model_stall();
        int a, b;
        a = instruction[11:8];
        b = instruction[7:4];
        return instrValid && !branchTaken && (busy[a] >= cyc || busy[b] >= cyc);
    endfunction

    task automatic one_cycle(input string tag, output bit bub);
        bit st;
        @(negedge clk);
        st = model_stall();
        chk({tag, ".PCWrite"}, {31'b0, PCWrite}, {31'b0, !st});
        chk({tag, ".IFIDWrite"}, {31'b0, IFIDWrite}, {31'b0, !st});
        chk({tag, ".IDEXBubble"}, {31'b0, IDEXBubble}, {31'b0, st});
        chk({tag, ".stallCount"}, 32'(stallCount), cnt);
        bub = IDEXBubble;
        if (st) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
        else if (instrValid && !branchTaken && mRead) begin
            int d = instruction[11:8];
            busy[d] = (busy[d] > cyc + L) ? busy[d] : cyc + L;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // holds the instruction while the model predicts a stall; returns observed bubble cycles
    task automatic issue(input string tag, input logic [15:0] ins, input logic v, input logic mr, output int bubs);
        bit b;
        instruction = ins; instrValid = v; mRead = mr;
        bubs = 0;
        for (int g = 0; g < 4 * L + 4; g++) begin
            bit st = model_stall();
            one_cycle(tag, b);
            if (b) bubs++;
            if (!st) break;
        end
    endtask

    initial begin
        int n;
        model_reset();
        #12;
        chk("rst.PCWrite", {31'b0, PCWrite}, 1);
        chk("rst.IFIDWrite", {31'b0, IFIDWrite}, 1);
        chk("rst.IDEXBubble", {31'b0, IDEXBubble}, 0);
        chk("rst.IFIDFlush", {31'b0, IFIDFlush}, 0);
        chk("rst.stallCount", 32'(stallCount), 0);
        @(posedge clk); #1 rst = 0;

        issue("ld", 16'h1200, 1, 1, n);
        issue("use_op2", 16'h0020, 1, 0, n);
        chk("use_op2.len", n, L);
        chk("use_op2.cnt", 32'(stallCount), L);

        issue("ld", 16'h1200, 1, 1, n);
        issue("gap", 16'h0000, 0, 0, n);
        issue("use_j2", 16'h0020, 1, 0, n);
        chk("use_j2.len", n, L - 1);

        issue("ld", 16'h1200, 1, 1, n);
        issue("indep", 16'h0345, 1, 0, n);
        chk("indep.len", n, 0);
        issue("nold", 16'h0200, 1, 0, n);
        issue("nold_use", 16'h0246, 1, 0, n);
        chk("nold_use.len", n, 0);

        repeat (L) issue("drain", 16'h0000, 0, 0, n);
        issue("ld_r0", 16'h1000, 1, 1, n);
        issue("use_r0", 16'h0010, 1, 0, n);
        chk("use_r0.len", n, L);

        // asynchronous reset in the second cycle of a stall
        issue("ld", 16'h1200, 1, 1, n);
        instruction = 16'h0246; instrValid = 1; mRead = 0;
        begin bit b; one_cycle("pre_rst", b); end
        #1 rst = 1;
        #1;
        chk("midrst.PCWrite", {31'b0, PCWrite}, 1);
        chk("midrst.IDEXBubble", {31'b0, IDEXBubble}, 0);
        chk("midrst.stallCount", 32'(stallCount), 0);
        model_reset();
        #1 rst = 0;
        issue("post_rst", 16'h0246, 1, 0, n);
        chk("post_rst.len", n, 0);

`ifdef HAZ_BRANCH_FLUSH_EN
        issue("ld", 16'h1200, 1, 1, n);
        branchTaken = 1;
        instruction = 16'h0246; instrValid = 1; mRead = 1;
        #1;
        chk("br.IFIDFlush", {31'b0, IFIDFlush}, 1);
        begin bit b; one_cycle("br", b); end
        branchTaken = 0;
        issue("after_br", 16'h0246, 1, 0, n);
        chk("after_br.len", n, L - 1);
`endif

        for (int i = 0; i < 250; i++) begin
            logic [15:0] ins;
            ins = {4'($urandom), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom)};
            issue("rand", ins, $urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, n);
        end
        chk("sat.stallCount", 32'(stallCount), cnt);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
